// File: rtl/cpu_pkg.sv
// Shared CPU execute-stage definitions: word widths, multiply sequencer states and the
// sign/magnitude helpers used by the multiply (and later divide) controllers.
package cpu_pkg;

  localparam int unsigned WORD_W  = 32;
  localparam int unsigned DWORD_W = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    WRITE = 2'd2
  } mult_state_t;

  // Magnitude of a possibly-signed word; 0x80000000 maps to itself as an unsigned value.
  function automatic logic [WORD_W-1:0] abs32(input logic [WORD_W-1:0] v,
                                               input logic              is_signed);
    logic [WORD_W-1:0] r;
    r = v;
    if (is_signed && v[WORD_W-1]) begin
      r = ~v + WORD_W'(1);
    end
    return r;
  endfunction

  function automatic logic [DWORD_W-1:0] neg64(input logic [DWORD_W-1:0] v);
    return ~v + DWORD_W'(1);
  endfunction

endpackage

// File: rtl/mult_hilo_ctrl.sv
// MULT/MULTU/MTHI/MTLO sequencer around an external pipelined unsigned 32x32 multiplier;
// owns HI/LO and stalls HI/LO reads while a product is in flight.
module mult_hilo_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned MUL_LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 is_signed,
  input  logic [WORD_W-1:0]    op_a,
  input  logic [WORD_W-1:0]    op_b,
  input  logic                 flush,
  input  logic                 mthi,
  input  logic                 mtlo,
  input  logic [WORD_W-1:0]    wdata,
  input  logic                 rd_hilo,
  output logic [WORD_W-1:0]    mul_a,
  output logic [WORD_W-1:0]    mul_b,
  input  logic [DWORD_W-1:0]   mul_r,
  output logic [WORD_W-1:0]    hi,
  output logic [WORD_W-1:0]    lo,
  output logic                 busy,
  output logic                 stall
);

  localparam int unsigned CntW = $clog2(MUL_LATENCY + 1);

  mult_state_t        state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               neg_q, neg_d;
  logic [WORD_W-1:0]  hi_q, hi_d;
  logic [WORD_W-1:0]  lo_q, lo_d;
  logic [WORD_W-1:0]  mul_a_q, mul_a_d;
  logic [WORD_W-1:0]  mul_b_q, mul_b_d;
  logic [DWORD_W-1:0] result;

  assign result = neg_q ? neg64(mul_r) : mul_r;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    mul_a_d = mul_a_q;
    mul_b_d = mul_b_q;
    case (state_q)
      IDLE: begin
        // mt writes land at the issue edge; a multiply issued alongside overwrites them later.
        if (mthi) hi_d = wdata;
        if (mtlo) lo_d = wdata;
        if (start && !flush) begin
          mul_a_d = abs32(op_a, is_signed);
          mul_b_d = abs32(op_b, is_signed);
          neg_d   = is_signed & (op_a[WORD_W-1] ^ op_b[WORD_W-1]);
          cnt_d   = CntW'(MUL_LATENCY);
          state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CntW'(1);
        if (flush) begin
          state_d = IDLE;
        end else if (cnt_q == CntW'(1)) begin
          state_d = WRITE;
        end
      end
      WRITE: begin
        state_d = IDLE;
        if (!flush) begin
          {hi_d, lo_d} = result;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      mul_a_q <= '0;
      mul_b_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      mul_a_q <= mul_a_d;
      mul_b_q <= mul_b_d;
    end
  end

  assign mul_a = mul_a_q;
  assign mul_b = mul_b_q;
  assign hi    = hi_q;
  assign lo    = lo_q;
  assign busy  = (state_q != IDLE);
  assign stall = rd_hilo & busy;

endmodule

// File: tb/tb_mult_hilo_ctrl.sv
// Directed and randomized bench for mult_hilo_ctrl with a behavioural pipelined multiplier.
module tb_mult_hilo_ctrl;

  localparam int unsigned L = 2;

  logic        clk = 1'b0;
  logic        reset, start, is_signed, flush, mthi, mtlo, rd_hilo;
  logic [31:0] op_a, op_b, wdata, mul_a, mul_b, hi, lo;
  logic [63:0] mul_r;
  logic        busy, stall;
  logic [63:0] pipe [L];

  int          total = 0;
  int          bad = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  mult_hilo_ctrl #(.MUL_LATENCY(L)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .is_signed(is_signed),
    .op_a     (op_a),
    .op_b     (op_b),
    .flush    (flush),
    .mthi     (mthi),
    .mtlo     (mtlo),
    .wdata    (wdata),
    .rd_hilo  (rd_hilo),
    .mul_a    (mul_a),
    .mul_b    (mul_b),
    .mul_r    (mul_r),
    .hi       (hi),
    .lo       (lo),
    .busy     (busy),
    .stall    (stall)
  );

  always #5 clk = ~clk;

  // External multiplier: L registered stages of an unsigned 64-bit product.
  always_ff @(posedge clk) begin
    pipe[0] <= {32'b0, mul_a} * {32'b0, mul_b};
    for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
  end
  assign mul_r = pipe[L-1];

  function automatic longint to_int(input logic [31:0] v, input logic s);
    return s ? longint'($signed(v)) : longint'({32'b0, v});
  endfunction

  function automatic logic [31:0] mag(input logic [31:0] v, input logic s);
    longint x;
    x = to_int(v, s);
    if (x < 0) x = -x;
    return x[31:0];
  endfunction

  function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b,
                                           input logic s);
    longint p;
    p = to_int(a, s) * to_int(b, s);
    return p;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one multiply at the current negedge; returns at the negedge where busy has fallen.
  task automatic do_mul(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input bit inject, input string tag);
    logic [63:0] p;
    p = ref_prod(a, b, s);
    start = 1'b1; is_signed = s; op_a = a; op_b = b; rd_hilo = 1'b1;
    #1;
    check({tag, " stall_idle"}, stall, 0);
    @(negedge clk);
    if (mthi) m_hi = wdata;
    if (mtlo) m_lo = wdata;
    if (inject) begin
      op_a = $urandom; op_b = $urandom; is_signed = 1'($urandom_range(0, 1));
      mthi = 1'b1; mtlo = 1'b1; wdata = $urandom;
    end else begin
      start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    end
    for (int i = 0; i <= int'(L); i++) begin
      check({tag, " busy"}, busy, 1);
      check({tag, " stall"}, stall, 1);
      check({tag, " mul_a"}, mul_a, mag(a, s));
      check({tag, " mul_b"}, mul_b, mag(b, s));
      @(negedge clk);
    end
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    m_hi = p[63:32];
    m_lo = p[31:0];
    check({tag, " busy_done"}, busy, 0);
    #1;
    check({tag, " stall_done"}, stall, 0);
    check({tag, " hi"}, hi, m_hi);
    check({tag, " lo"}, lo, m_lo);
    rd_hilo = 1'b0;
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic        rs;
    reset = 1'b1; start = 0; is_signed = 0; flush = 0; mthi = 0; mtlo = 0;
    rd_hilo = 0; op_a = 0; op_b = 0; wdata = 0;
    repeat (2) @(negedge clk);
    check("rst hi", hi, 0);
    check("rst lo", lo, 0);
    check("rst mul_a", mul_a, 0);
    check("rst busy", busy, 0);
    reset = 1'b0;
    @(negedge clk);

    do_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, "multu_max");
    check("multu_max hi_const", hi, 32'hFFFF_FFFE);
    check("multu_max lo_const", lo, 32'h0000_0001);
    do_mul(32'hFFFF_FFFD, 32'd5, 1'b1, 1'b0, "mult_neg");
    check("mult_neg hi_const", hi, 32'hFFFF_FFFF);
    check("mult_neg lo_const", lo, 32'hFFFF_FFF1);
    do_mul(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0, "mult_min");
    do_mul(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, "multu_min");
    check("min hi_const", hi, 32'h4000_0000);
    // Second start held during busy is ignored; the next issue is back-to-back.
    do_mul(32'd1234567, 32'hFFFF_FF00, 1'b1, 1'b1, "inject");
    do_mul(32'd11, 32'd13, 1'b0, 1'b0, "b2b");

    mthi = 1'b1; wdata = 32'h1234_5678;
    @(negedge clk);
    mthi = 1'b0; m_hi = 32'h1234_5678;
    check("mthi hi", hi, m_hi);
    check("mthi lo", lo, m_lo);
    start = 1'b1; is_signed = 1'b0; op_a = 32'd7; op_b = 32'd6;
    @(negedge clk);
    start = 1'b0;
    check("flush busy1", busy, 1);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush busy", busy, 0);
    check("flush hi", hi, m_hi);
    check("flush lo", lo, m_lo);

    start = 1'b1; flush = 1'b1; op_a = 32'd3; op_b = 32'd3;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("flush_start busy", busy, 0);

    // mtlo issued alongside a multiply: visible first, then overwritten by the product.
    mtlo = 1'b1; wdata = 32'hCAFE_F00D;
    do_mul(32'hFFFF_FFFE, 32'hFFFF_FFFE, 1'b1, 1'b0, "mt_with_start");

    start = 1'b1; is_signed = 1'b0; op_a = 32'd5; op_b = 32'd9;
    @(negedge clk);
    start = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    m_hi = '0; m_lo = '0;
    check("async hi", hi, 0);
    check("async lo", lo, 0);
    check("async mul_a", mul_a, 0);
    check("async mul_b", mul_b, 0);
    check("async busy", busy, 0);
    @(negedge clk);
    reset = 1'b0;
    do_mul(32'd2, 32'd3, 1'b0, 1'b0, "post_rst");

    for (int n = 0; n < 24; n++) begin
      ra = $urandom; rb = $urandom; rs = 1'($urandom_range(0, 1));
      if (n % 6 == 1) ra = 32'h8000_0000;
      if (n % 6 == 2) rb = 32'hFFFF_FFFF;
      if (n % 5 == 3) begin
        mthi = 1'b1; mtlo = 1'($urandom_range(0, 1)); wdata = $urandom;
        @(negedge clk);
        m_hi = wdata;
        if (mtlo) m_lo = wdata;
        mthi = 1'b0; mtlo = 1'b0;
        check("rand mt hi", hi, m_hi);
        check("rand mt lo", lo, m_lo);
      end
      do_mul(ra, rb, rs, (n % 4 == 0), "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
